// File: rtl/ram_sp_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package ram_sp_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Widest word the zero helper can supply.
  localparam int unsigned MaxDataW = 1024;
  localparam logic [MaxDataW-1:0] ZeroWord = '0;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage array: per-byte write enables and a registered read port; no reset.
module ram_sp_array #(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic               clk_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [DataW/8-1:0] be_i,
  input  logic [DataW-1:0]   wdata_i,
  input  logic               re_i,
  output logic [DataW-1:0]   rdata_o
);

  localparam int unsigned NumBytes = DataW / 8;
  localparam int unsigned Depth    = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumBytes; k++) begin
      if (be_i[k]) begin
        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sp_param.sv
// Single-port RAM top: clear sweep FSM, access arbitration, rd_valid/err strobes.
module ram_sp_param
  import ram_sp_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_in,
  input  logic                re_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W/8-1:0] be_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                clr_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                ready,
  output logic                err
);

  localparam int unsigned NumBytes = byte_lanes(DATA_W);

  if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MaxDataW) begin : g_bad_width
    $error("ram_sp_param: DATA_W must be a non-zero multiple of 8");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;
  logic                rd_zero_q, rd_zero_d;

  logic                idle, clearing, wr_acc, rd_acc;
  logic [ADDR_W-1:0]   mem_addr;
  logic [NumBytes-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_re;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    clearing = (state_q == ST_CLEAR);
    wr_acc   = idle & ~clr_in & we_in & ~re_in;
    rd_acc   = idle & ~clr_in & re_in & ~we_in;

    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_in) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // Rejected: busy, pre-empted by clr_in, or read/write collision.
    err_d      = (we_in | re_in) & (~idle | clr_in | (we_in & re_in));
    rd_valid_d = rd_acc;
    rd_zero_d  = rd_zero_q & ~rd_acc;
  end

  always_comb begin
    mem_addr  = clearing ? clr_addr_q : addr_in;
    mem_wdata = clearing ? ZeroWord[DATA_W-1:0] : data_in;
    mem_be    = '0;
    if (!rst) begin
      if (clearing) begin
        mem_be = '1;
      end else if (wr_acc) begin
        mem_be = be_in;
      end
    end
    mem_re = rd_acc & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  ram_sp_array #(
    .DataW(DATA_W),
    .AddrW(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .addr_i (mem_addr),
    .be_i   (mem_be),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .rdata_o(mem_rdata)
  );

  // The array read register has no reset, so mask it until the first read.
  assign data_out = rd_zero_q ? '0 : mem_rdata;
  assign rd_valid = rd_valid_q;
  assign ready    = idle;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Randomised scoreboard bench for ram_sp_param (DATA_W=16, ADDR_W=4).
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst, we_in, re_in, clr_in;
  logic [3:0]  addr_in;
  logic [1:0]  be_in;
  logic [15:0] data_in, data_out;
  logic        rd_valid, ready, err;

  ram_sp_param #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we_in   (we_in),
    .re_in   (re_in),
    .addr_in (addr_in),
    .be_in   (be_in),
    .data_in (data_in),
    .clr_in  (clr_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .ready   (ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int rv_run   = 0;
  int rv_last_run = 0;

  logic [15:0] model_mem [16];
  logic [15:0] exp_q [$];
  bit          bench_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected word whenever the DUT flags a read result.
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (rd_valid === 1'b1) begin
      rv_run++;
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
      end else begin
        chk("read_data", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
      end
    end else begin
      if (rv_run != 0) rv_last_run = rv_run;
      rv_run = 0;
    end
  end

  task automatic model_zero();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
  endtask

  // One bus cycle: drive, update the reference model, step past the edge.
  task automatic cyc(input logic we, input logic re, input logic [3:0] a,
                     input logic [1:0] be, input logic [15:0] d, input logic clr);
    we_in = we; re_in = re; addr_in = a; be_in = be; data_in = d; clr_in = clr;
    if (!bench_ready) begin
      if (we || re) err_exp++;
    end else if (clr) begin
      if (we || re) err_exp++;
      model_zero();
      bench_ready = 1'b0;
    end else if (we && re) begin
      err_exp++;
    end else if (we) begin
      for (int k = 0; k < 2; k++)
        if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
    end else if (re) begin
      exp_q.push_back(model_mem[a]);
    end
    @(posedge clk); #1;
    we_in = 1'b0; re_in = 1'b0; clr_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 2'b00, 16'h0000, 1'b0);
  endtask

  // Called in the first busy cycle; ready must first be seen high in cycle 17.
  task automatic wait_ready(input string name);
    int first;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        first = i;
        break;
      end
    end
    chk(name, first, 32'd17);
    bench_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, 4'(a), 2'b00, 16'h0000, 1'b0);
    idle_cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we_in = 1'b0; re_in = 1'b0; clr_in = 1'b0;
    addr_in = '0; be_in = '0; data_in = '0;
    bench_ready = 1'b0;
    model_zero();

    // Reset and initial clear
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", {16'd0, data_out}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    wait_ready("ready_after_reset");
    read_all();
    chk("initial_read_run", rv_last_run, 32'd16);

    // Byte-enable merge
    cyc(1'b1, 1'b0, 4'd5, 2'b11, 16'hABCD, 1'b0);
    cyc(1'b1, 1'b0, 4'd5, 2'b10, 16'h1200, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 2'b00, 16'h0000, 1'b0);
    chk("be_merge_data", {16'd0, data_out}, 32'h12CD);
    chk("be_merge_valid", {31'd0, rd_valid}, 32'd1);
    cyc(1'b1, 1'b0, 4'd6, 2'b00, 16'hFFFF, 1'b0);
    chk("be_valid_drop", {31'd0, rd_valid}, 32'd0);
    chk("be_zero_noerr", {31'd0, err}, 32'd0);
    idle_cycles(1);

    // Back-to-back writes then reads
    for (int a = 0; a < 16; a++) cyc(1'b1, 1'b0, 4'(a), 2'b11, 16'(a * 16'h0101), 1'b0);
    read_all();
    chk("b2b_read_run", rv_last_run, 32'd16);

    // Collision leaves array and data_out untouched
    cyc(1'b0, 1'b1, 4'd3, 2'b00, 16'h0000, 1'b0);
    cyc(1'b1, 1'b1, 4'd3, 2'b11, 16'hFFFF, 1'b0);
    chk("collision_err", {31'd0, err}, 32'd1);
    chk("collision_hold", {16'd0, data_out}, 32'h0303);
    chk("collision_no_valid", {31'd0, rd_valid}, 32'd0);
    cyc(1'b0, 1'b1, 4'd3, 2'b00, 16'h0000, 1'b0);
    idle_cycles(1);

    // clr_in with a same-cycle write
    cyc(1'b1, 1'b0, 4'd3, 2'b11, 16'hFFFF, 1'b1);
    chk("clr_err", {31'd0, err}, 32'd1);
    wait_ready("ready_after_clr");
    read_all();
    chk("err_count_directed", err_seen, err_exp);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       cyc(1'b1, 1'b0, 4'($urandom), 2'($urandom), 16'($urandom), 1'b0);
      else if (r < 8)  cyc(1'b0, 1'b1, 4'($urandom), 2'b00, 16'h0000, 1'b0);
      else if (r == 8) cyc(1'b1, 1'b1, 4'($urandom), 2'($urandom), 16'($urandom), 1'b0);
      else             idle_cycles(1);
    end
    cyc(1'b1, 1'b0, 4'd7, 2'b11, 16'hBEEF, 1'b0);
    cyc(1'b0, 1'b1, 4'd7, 2'b00, 16'h0000, 1'b0);
    idle_cycles(2);
    chk("err_count_random", err_seen, err_exp);

    // Reset during a clear sweep restarts it
    cyc(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000, 1'b1);
    idle_cycles(2);
    cyc(1'b1, 1'b0, 4'd2, 2'b11, 16'h1234, 1'b0);
    idle_cycles(4);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midsweep_rst_data_out", {16'd0, data_out}, 32'd0);
    chk("midsweep_rst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
    wait_ready("ready_after_midsweep_rst");
    cyc(1'b1, 1'b0, 4'd15, 2'b11, 16'h5A5A, 1'b0);
    cyc(1'b0, 1'b1, 4'd15, 2'b00, 16'h0000, 1'b0);
    chk("final_rd_data", {16'd0, data_out}, 32'h5A5A);
    idle_cycles(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("err_count_final", err_seen, err_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
